// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle RV-M unit that sits beside the EX-stage ALU.
// It runs MUL/MULH/MULHSU/MULHU with an iterative shift-add multiplier and
// DIV/DIVU/REM/REMU with a restoring divider. Each operation iterates on
// operand magnitudes, and the sign is applied to the result at the end.
// Optional build macro EX_MULDIV_FAST_MUL_EN: the MUL* ops use a
// combinational multiplier and complete in one cycle. Divide is always
// iterative.
module ex_muldiv #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] oper1_i,
    input  logic [XLEN-1:0] oper2_i,
    input  logic            stall_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam int unsigned CntW = $clog2(XLEN);
    localparam logic [CntW-1:0] CntInit = CntW'(XLEN - 1);
    localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] OpMul    = 3'd0;
    localparam logic [2:0] OpMulh   = 3'd1;
    localparam logic [2:0] OpMulhsu = 3'd2;
    localparam logic [2:0] OpMulhu  = 3'd3;
    localparam logic [2:0] OpDiv    = 3'd4;
    localparam logic [2:0] OpDivu   = 3'd5;
    localparam logic [2:0] OpRem    = 3'd6;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e            state_q;
    logic [2:0]        op_q;
    logic [CntW-1:0]   cnt_q;
    logic              neg_q;
    // hi_q/lo_q hold the product halves for a multiply, and the
    // remainder/quotient for a divide. b_q holds the multiplicand or divisor.
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;
    logic [XLEN-1:0]   b_q;
    logic              valid_q;
    logic [XLEN-1:0]   result_q;

    logic              op1_signed, op2_signed, sign1, sign2, res_neg;
    logic [XLEN-1:0]   mag1, mag2;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   special_res;

    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   mul_hi_n, mul_lo_n;
    logic [XLEN:0]     div_trial;
    logic [XLEN-1:0]   div_diff;
    logic              div_ge;
    logic [XLEN-1:0]   div_hi_n, div_lo_n;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;
    logic [XLEN-1:0]   calc_res;

`ifdef EX_MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    logic [XLEN-1:0]   fast_res;
`endif

    // Decode the issuing instruction: operand magnitudes, result sign, special divides
    always_comb begin
        op1_signed  = (op_i == OpMulh) || (op_i == OpMulhsu) || (op_i == OpDiv) || (op_i == OpRem);
        op2_signed  = (op_i == OpMulh) || (op_i == OpDiv) || (op_i == OpRem);
        sign1       = op1_signed & oper1_i[XLEN-1];
        sign2       = op2_signed & oper2_i[XLEN-1];
        mag1        = sign1 ? -oper1_i : oper1_i;
        mag2        = sign2 ? -oper2_i : oper2_i;
        // The remainder takes the dividend's sign. Every other op takes sign1 ^ sign2.
        res_neg     = (op_i == OpRem) ? sign1 : (sign1 ^ sign2);
        div_zero    = op_i[2] && (oper2_i == '0);
        div_ovf     = ((op_i == OpDiv) || (op_i == OpRem)) && (oper1_i == MinInt) &&
                      (oper2_i == '1);
        // op_i[1] separates REM* (bit set) from DIV*
        if (div_zero) begin
            special_res = op_i[1] ? oper1_i : '1;
        end else begin
            special_res = op_i[1] ? '0 : MinInt;
        end
    end

    // One multiply step (add, then shift right) and one restoring-divide step
    always_comb begin
        mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : '0)};
        mul_hi_n  = mul_sum[XLEN:1];
        mul_lo_n  = {mul_sum[0], lo_q[XLEN-1:1]};
        div_trial = {hi_q, lo_q[XLEN-1]};
        div_ge    = div_trial >= {1'b0, b_q};
        // When the trial is at least the divisor, the true difference is smaller than the divisor
        div_diff  = div_trial[XLEN-1:0] - b_q;
        div_hi_n  = div_ge ? div_diff : div_trial[XLEN-1:0];
        div_lo_n  = {lo_q[XLEN-2:0], div_ge};
    end

    // Sign fixup and result selection for the final iteration
    always_comb begin
        prod_fix = neg_q ? -{mul_hi_n, mul_lo_n} : {mul_hi_n, mul_lo_n};
        quo_fix  = neg_q ? -div_lo_n : div_lo_n;
        rem_fix  = neg_q ? -div_hi_n : div_hi_n;
        case (op_q)
            OpMul:                     calc_res = prod_fix[XLEN-1:0];
            OpMulh, OpMulhsu, OpMulhu: calc_res = prod_fix[2*XLEN-1:XLEN];
            OpDiv, OpDivu:             calc_res = quo_fix;
            default:                   calc_res = rem_fix;
        endcase
    end

`ifdef EX_MULDIV_FAST_MUL_EN
    // Single-cycle signed-magnitude product for the MUL* ops
    always_comb begin
        fast_prod = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
        if (res_neg) begin
            fast_prod = -fast_prod;
        end
        fast_res = (op_i == OpMul) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif

    // Stall request: raised while an accepted op is in flight, dropped during a flush
    always_comb begin
        busy_o = ~flush_i & (((state_q == StIdle) & start_i) | (state_q == StCalc));
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= StIdle;
            op_q     <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else if (flush_i) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        op_q  <= op_i;
                        neg_q <= res_neg;
                        cnt_q <= CntInit;
                        if (div_zero || div_ovf) begin
                            result_q <= special_res;
                            valid_q  <= 1'b1;
                            state_q  <= StDone;
`ifdef EX_MULDIV_FAST_MUL_EN
                        end else if (!op_i[2]) begin
                            result_q <= fast_res;
                            valid_q  <= 1'b1;
                            state_q  <= StDone;
`endif
                        end else begin
                            // lo_q holds the multiplier or the dividend. Both shift out one bit per step.
                            hi_q    <= '0;
                            lo_q    <= mag1;
                            b_q     <= mag2;
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    if (op_q[2]) begin
                        hi_q <= div_hi_n;
                        lo_q <= div_lo_n;
                    end else begin
                        hi_q <= mul_hi_n;
                        lo_q <= mul_lo_n;
                    end
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        result_q <= calc_res;
                        valid_q  <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    // start_i is ignored here so the instruction still in EX is not issued again
                    if (!stall_i) begin
                        valid_q <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign valid_o  = valid_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: bench for ex_muldiv (XLEN = 32). The driver issues
// operations and pushes the expected result and latency onto a scoreboard.
// A monitor on the falling edge pops an entry at every new valid result.
module tb_ex_muldiv;

    localparam int XLEN = 32;
    localparam logic [31:0] MinInt = 32'h8000_0000;
`ifdef EX_MULDIV_FAST_MUL_EN
    localparam bit Fast = 1'b1;
`else
    localparam bit Fast = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        valid;
    logic [31:0] res;

    ex_muldiv #(.XLEN(XLEN)) dut (
        .clk_i   (clk),
        .rstn_i  (rstn),
        .start_i (start),
        .op_i    (op),
        .oper1_i (a),
        .oper2_i (b),
        .stall_i (stall),
        .flush_i (flush),
        .busy_o  (busy),
        .valid_o (valid),
        .result_o(res)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          c0;
        int          lat;
        logic [2:0]  op;
        logic [31:0] x;
        logic [31:0] y;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;

    // Reference: plain 64-bit arithmetic following the RV-M rules
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint ux = longint'({32'b0, x});
        longint uy = longint'({32'b0, y});
        logic [63:0] p;
        case (o)
            3'd0: begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
            3'd1: begin p = 64'(sx * sy); return p[63:32]; end
            3'd2: begin p = 64'(sx * uy); return p[63:32]; end
            3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == MinInt && y == 32'hFFFF_FFFF) return MinInt;
                return 32'(sx / sy);
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : 32'(ux / uy);
            3'd6: begin
                if (y == 0) return x;
                if (x == MinInt && y == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sx % sy);
            end
            default: return (y == 0) ? x : 32'(ux % uy);
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o[2]) begin
            if (y == 0) return 1;
            if ((o == 3'd4 || o == 3'd6) && x == MinInt && y == 32'hFFFF_FFFF) return 1;
            return XLEN + 1;
        end
        return Fast ? 1 : XLEN + 1;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    // Scoreboard monitor
    exp_t        e;
    logic        pv = 1'b0;
    logic [31:0] held = '0;
    int          brun = 0;
    always @(negedge clk) begin
        if (!rstn) begin
            pv   = 1'b0;
            brun = 0;
        end else begin
            if (flush) brun = 0;
            else if (busy) brun++;
            if (valid && !pv) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_valid: got result %h, required no result", res);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("result op%0d %h,%h", e.op, e.x, e.y), res, e.res);
                    check_int($sformatf("latency op%0d", e.op), cyc - e.c0, e.lat);
                    check_int($sformatf("busy_cycles op%0d", e.op), brun, e.lat);
                end
                brun = 0;
                held = res;
            end else if (valid && pv) begin
                check("hold_stable", res, held);
            end
            pv = valid;
        end
    end

    // Called at posedge+#1 with the unit idle. Returns at the next posedge+#1.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] want, input bit track);
        exp_t n;
        n.res = want; n.c0 = cyc; n.lat = lat_of(o, x, y); n.op = o; n.x = x; n.y = y;
        if (track) sb.push_back(n);
        op = o; a = x; b = y; start = 1'b1;
        #1 check("busy_at_issue", {31'b0, busy}, 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk); #1;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL timeout: got %0d pending results, required 0", sb.size());
            sb.delete();
        end
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return MinInt;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [2:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] r;
    } vec_t;

    vec_t dir[12] = '{
        '{3'd5, 32'd100, 32'd7, 32'd14},
        '{3'd7, 32'd100, 32'd7, 32'd2},
        '{3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF},
        '{3'd7, 32'd5, 32'd0, 32'd5},
        '{3'd4, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFFF},
        '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
        '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0},
        '{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF},
        '{3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA},
        '{3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF},
        '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
        '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}
    };

    initial begin
        logic [2:0]  ro;
        logic [31:0] rx, ry;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", {31'b0, valid}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_result", res, 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        foreach (dir[i]) begin
            issue(dir[i].o, dir[i].x, dir[i].y, dir[i].r, 1'b1);
            wait_done();
        end

        // Flush at cycle 10 of a DIVU: no result, busy low in the flush cycle
        issue(3'd5, 32'd1000, 32'd3, 32'd0, 1'b0);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        #1 check("flush_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_idle_busy", {31'b0, busy}, 32'd0);
        repeat (40) begin @(posedge clk); #1; end
        check("flush_no_valid", {31'b0, valid}, 32'd0);
        issue(3'd5, 32'd9, 32'd3, 32'd3, 1'b1);
        wait_done();

        // Stall in DONE with start held high
        rx = 32'h1234_5678;
        ry = 32'h9ABC_DEF0;
        issue(3'd3, rx, ry, model(3'd3, rx, ry), 1'b1);
        for (int i = 0; i < 100; i++) begin
            if (valid) break;
            @(posedge clk); #1;
        end
        stall = 1'b1;
        start = 1'b1;
        #1 check("done_busy", {31'b0, busy}, 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            check("stall_valid", {31'b0, valid}, 32'd1);
        end
        stall = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        check("after_stall_valid", {31'b0, valid}, 32'd0);
        check("after_stall_busy", {31'b0, busy}, 32'd0);
        repeat (5) begin @(posedge clk); #1; end
        check("no_reissue", {31'b0, valid}, 32'd0);
        wait_done();

        // Asynchronous reset mid-operation
        issue(3'd5, 32'hDEAD_BEEF, 32'd17, model(3'd5, 32'hDEAD_BEEF, 32'd17), 1'b1);
        repeat (5) begin @(posedge clk); #1; end
        #2 rstn = 1'b0;
        #1;
        check("midreset_valid", {31'b0, valid}, 32'd0);
        check("midreset_busy", {31'b0, busy}, 32'd0);
        check("midreset_result", res, 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        // Randomized operations, issued back to back
        for (int i = 0; i < 150; i++) begin
            ro = 3'($urandom_range(0, 7));
            rx = rnd_opnd();
            ry = rnd_opnd();
            issue(ro, rx, ry, model(ro, rx, ry), 1'b1);
            wait_done();
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, required finish within 1000000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

- Parametrised multi-cycle RV-M arithmetic unit beside the execute stage ALU.
- Performs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on forwarded operands using iterative shift-add multiply and restoring divide.
- Raises `busy_o` so the hazard unit stalls IF/ID/EX while an operation is in flight.
- Delivers a registered result for one EX/MEM capture.

## Interface
Parameters:
- `XLEN`, 32: operand/result width; even, ≥ 8.

Ports:
- `clk_i` in 1: clock, single domain.
- `rstn_i` in 1: asynchronous active-low reset.
- `start_i` in 1: valid M-extension instruction present in EX.
- `op_i` in 3: funct3 encoding. 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `oper1_i` in XLEN: rs1 value, after forwarding.
- `oper2_i` in XLEN: rs2 value, after forwarding.
- `stall_i` in 1: downstream stall; holds a completed result.
- `flush_i` in 1: pipeline flush; aborts any operation.
- `busy_o` out 1: combinational stall request to the hazard unit.
- `valid_o` out 1: registered; `result_o` is valid.
- `result_o` out XLEN: registered result.

## Operation
- States: IDLE, CALC, DONE.
- **IDLE:** when `start_i & ~flush_i`:
  - Latch `op_i`.
  - Latch operand magnitudes: signed operands are negated if negative. Op1 is signed for MULH, MULHSU, DIV, REM. Op2 is signed for MULH, DIV, REM.
  - Record result sign:
    - MUL*: sign1 ^ sign2.
    - DIV: sign1 ^ sign2.
    - REM: sign of the dividend.
  - Load counter with XLEN-1 and go to CALC.
- **Special divides** bypass CALC and go straight to DONE:
  - Divisor 0: quotient all-ones, remainder = `oper1_i`.
  - Signed DIV/REM of MIN_INT by -1: quotient = MIN_INT, remainder 0.
- **CALC:** one iteration per cycle.
  - Multiply: 2·XLEN-bit shift-add accumulator.
  - Divide: restoring; subtract/compare on an XLEN+1-bit partial remainder.
  - When counter reaches 0, apply sign fixup (two's complement of the 2·XLEN product or of the quotient/remainder) and go to DONE.
  - Result selection:
    - MUL: low half of the product.
    - MULH*: high half of the product.
    - DIV*: quotient.
    - REM*: remainder.
- **DONE:** `valid_o`=1.
  - Stays in DONE while `stall_i`.
  - Otherwise goes to IDLE.
  - `start_i` is ignored in DONE, so the same instruction is not re-issued.
- **`busy_o`** = (IDLE & `start_i` & ~`flush_i`) | CALC. It is 0 in DONE, releasing the pipeline.
- **`flush_i`** in any state:
  - Next state is IDLE and `valid_o` goes 0 next cycle.
  - `busy_o` is 0 in the flush cycle.
  - No result is delivered.
- **Arithmetic:** all arithmetic is modulo 2^XLEN, with no exceptions. MULHSU treats op2 as unsigned.

## Timing
- Reset values: state IDLE, `busy_o` 0, `valid_o` 0, `result_o` 0, counter 0.
- Normal operation, with `start_i` sampled in IDLE at cycle 0:
  - Iterations run in cycles 1..XLEN.
  - `valid_o` is high at cycle XLEN+1.
  - Latency is XLEN+1 cycles.
  - `busy_o` is high in cycles 0..XLEN.
- Special divides: `valid_o` is high at cycle 1 and `busy_o` is high in cycle 0 only.
- `result_o` is stable for every cycle `valid_o`=1.
- Back-to-back: a new `start_i` is accepted in the first IDLE cycle after DONE. The minimum gap between consecutive valid results is 2 cycles.
- `flush_i` and `stall_i` together: flush wins.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous).

## Configuration
- Macro: `EX_MULDIV_FAST_MUL_EN`.
- **Defined:** MUL* ops use a combinational XLEN×XLEN multiplier. Result and sign fixup are registered directly into DONE, so latency is 1 cycle and `busy_o` is high in cycle 0 only.
- **Undefined:** MUL* ops use the iterative path, with latency XLEN+1.
- Divide is iterative in both builds.

## Test plan
- **DIVU/REMU:** DIVU 100/7 (XLEN=32) -> `valid_o` at cycle 33, `result_o`=14. REMU 100/7 -> 2. `busy_o` high for cycles 0..32.
- **Divide by zero:** DIVU 5/0 -> `result_o`=0xFFFFFFFF at cycle 1. REMU 5/0 -> 5. DIV -9/0 -> 0xFFFFFFFF.
- **Signed overflow:** DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at cycle 1. REM of the same operands -> 0. REM -7/2 -> 0xFFFFFFFF.
- **Multiply variants** with operands 0xFFFFFFFE × 3:
  - MUL -> 0xFFFFFFFA.
  - MULH -> 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
  - Latency 33 cycles without the macro, 1 cycle with it.
- **Flush mid-divide:** assert `flush_i` at cycle 10 of a DIVU -> `busy_o` 0 that cycle and `valid_o` never asserts. Then start DIVU 9/3 -> 3 at its normal latency.
- **Stall in DONE:** hold `stall_i` for 3 cycles while in DONE with `start_i` high -> `valid_o` stays 1 and `result_o` is unchanged. When `stall_i` drops, the unit returns to IDLE with no re-issue.
